seven_segment_scan_driver: RTL
==============================

Name: seven_segment_scan_driver

Overview:
- Display-side consumer for the four-bit counter family on the BASYS2 board.
- Takes a 16-bit hex value and drives the on-board 4-digit multiplexed seven-segment display.
- Drives anodes and cathodes active-low, with per-digit enable and decimal-point control.
- Samples the value once per scan frame so a digit never shows a half-updated count.

Parameters:
- SCAN_SCALER_BITS, 16, prescaler width; each digit slot lasts 2^SCAN_SCALER_BITS clocks (763 Hz per digit at 50 MHz). Minimum legal value is 2.

Ports:
- systemClock  input  1  board clock; all logic on its rising edge.
- resetButtonN  input  1  synchronous, active-low reset.
- value  input  16  hex value to display; nibble k goes to digit k (digit 3 = leftmost = value[15:12]).
- digitEnable  input  4  bit k high enables digit k; low blanks it.
- decimalPoints  input  4  bit k high lights the DP of digit k.
- anodes  output  4  active-low digit selects; bit k drives digit k.
- segments  output  7  active-low cathodes, order {g,f,e,d,c,b,a}.
- decimalPoint  output  1  active-low DP cathode.
- frameStart  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (resetButtonN low at a clock edge) sets:
  - prescaler = 0, digitIndex = 0;
  - value/enable/DP shadows = 0;
  - anodes = 4'b1111, segments = 7'b1111111, decimalPoint = 1, frameStart = 0.
- Reset mid-frame aborts the scan immediately at that edge; there is no partial-digit completion.
- Prescaler: increments every clock and wraps modulo 2^SCAN_SCALER_BITS. "tick" = prescaler all-ones.
- digitIndex (2 bits): on tick it advances 0→1→2→3→0; otherwise it holds.
- Snapshot: on a tick with digitIndex == 3, the shadows load value, digitEnable and decimalPoints.
  - frameStart is registered and is high for exactly the following cycle.
  - Input changes at any other time are invisible until the next snapshot.
  - After reset, the shadows stay 0 until the first snapshot; the first frame shows nothing because the enable shadow is 0.
- Outputs are all registered, one clock after the digitIndex/shadow state they reflect:
  - anodes = ~(1 << digitIndex) when the enable shadow bit [digitIndex] is 1, else 4'b1111.
  - segments = hexDecode(nibble[digitIndex]) when enabled, else 7'b1111111.
  - decimalPoint = ~dpShadow[digitIndex] when enabled, else 1.
- Hex decode, active-low {g..a}, nibbles 0..F:
  - 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- Exactly one anode is low at any time, or none. Two anodes low is an error.
- Frame length is 4 × 2^SCAN_SCALER_BITS clocks. The digit changes at the same point in every slot, so there is no jitter.

Optional Feature:
- Macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k = 3, 2, 1) is also blanked when every shadow nibble from k up to 3 is zero.
  - A blanked digit drives anodes 1111, segments 1111111 and decimalPoint 1 for that slot.
  - Digit 0 is never blanked by this rule.
  - This rule is ANDed with digitEnable; it never un-blanks a digit.
- Undefined: zeros are always displayed. No extra logic is synthesized.

Test Plan (SCAN_SCALER_BITS=2: slot 4 clocks, frame 16 clocks):
- Reset: hold resetButtonN low for 3 clocks → anodes 1111, segments 7F, decimalPoint 1, frameStart 0. Outputs stay blank through the first full frame.
- Scan order: value=16'h1234, digitEnable=4'hF, decimalPoints=0 → after the first frameStart, successive 4-clock slots show:
  - anodes 1110/segments 19 (digit 0 = 4);
  - 1101/30;
  - 1011/24;
  - 0111/79.
  - Pattern repeats every 16 clocks, with frameStart pulsing once per 16.
- Snapshot isolation: change value 16'h1234→16'hABCD mid-frame → remaining slots still show 1234. The next frame shows segments 21 (d), 46 (C), 03 (b), 08 (A).
- Enable/DP: digitEnable=4'b0101, decimalPoints=4'b0001, value=16'h0008 →
  - digit 0: anodes 1110, segments 00, decimalPoint 0;
  - digits 1 and 3: anodes 1111 for their whole slot;
  - digit 2: anodes 1011, segments 40.
- Reset mid-scan: assert resetButtonN low during the digit-2 slot → the next edge gives anodes 1111; after release the scan restarts at digit 0 with prescaler 0.
- Leading-zero blank (macro defined): value=16'h0050, digitEnable=4'hF → digits 3 and 2 are blank, digit 1 shows 12, digit 0 shows 40. With value=16'h0000, only digit 0 lights, showing 40.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame snapshot of value/enable/DP.
// Optional macro SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN blanks leading zero digits (3..1).
module seven_segment_scan_driver #(
    parameter int SCAN_SCALER_BITS = 16
) (
    input  logic        systemClock,
    input  logic        resetButtonN,
    input  logic [15:0] value,
    input  logic [3:0]  digitEnable,
    input  logic [3:0]  decimalPoints,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        decimalPoint,
    output logic        frameStart
);

    localparam logic [SCAN_SCALER_BITS-1:0] PRESCALER_ONE  = {{(SCAN_SCALER_BITS-1){1'b0}}, 1'b1};
    localparam logic [SCAN_SCALER_BITS-1:0] PRESCALER_ZERO = {SCAN_SCALER_BITS{1'b0}};

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hexDecode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [SCAN_SCALER_BITS-1:0] prescaler_r;
    logic [1:0]  digitIndex_r;
    logic [15:0] valueShadow_r;
    logic [3:0]  enableShadow_r;
    logic [3:0]  dpShadow_r;
    logic [3:0]  anodes_r;
    logic [6:0]  segments_r;
    logic        decimalPoint_r;
    logic        frameStart_r;

    logic        tick_s;
    logic        frameEnd_s;
    logic [3:0]  nibble_s;
    logic        leadingBlank_s;
    logic        digitLit_s;
    logic [3:0]  anodesNext_s;
    logic [6:0]  segmentsNext_s;
    logic        decimalPointNext_s;

    assign tick_s     = &prescaler_r;
    assign frameEnd_s = tick_s && (digitIndex_r == 2'd3);

    // Select the shadow nibble for the digit currently being scanned.
    always_comb begin
        nibble_s = 4'h0;
        case (digitIndex_r)
            2'd0:    nibble_s = valueShadow_r[3:0];
            2'd1:    nibble_s = valueShadow_r[7:4];
            2'd2:    nibble_s = valueShadow_r[11:8];
            2'd3:    nibble_s = valueShadow_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic [3:0] zeroFromTop_s;

    // zeroFromTop_s[k] is set when every shadow nibble from k up to 3 is zero; digit 0 is exempt.
    always_comb begin
        zeroFromTop_s    = 4'b0000;
        zeroFromTop_s[3] = (valueShadow_r[15:12] == 4'h0);
        zeroFromTop_s[2] = zeroFromTop_s[3] && (valueShadow_r[11:8] == 4'h0);
        zeroFromTop_s[1] = zeroFromTop_s[2] && (valueShadow_r[7:4] == 4'h0);
        zeroFromTop_s[0] = 1'b0;
    end

    assign leadingBlank_s = zeroFromTop_s[digitIndex_r];
`else
    assign leadingBlank_s = 1'b0;
`endif

    assign digitLit_s = enableShadow_r[digitIndex_r] && !leadingBlank_s;

    // Next-cycle display drive for the scanned digit; a dark digit releases every line.
    always_comb begin
        anodesNext_s       = 4'b1111;
        segmentsNext_s     = 7'b1111111;
        decimalPointNext_s = 1'b1;
        if (digitLit_s) begin
            anodesNext_s       = ~(4'b0001 << digitIndex_r);
            segmentsNext_s     = hexDecode(nibble_s);
            decimalPointNext_s = ~dpShadow_r[digitIndex_r];
        end else begin
            anodesNext_s       = 4'b1111;
            segmentsNext_s     = 7'b1111111;
            decimalPointNext_s = 1'b1;
        end
    end

    // Scan timing and frame snapshot; inputs are only observed at the end of digit 3's slot.
    always_ff @(posedge systemClock) begin
        if (!resetButtonN) begin
            prescaler_r    <= PRESCALER_ZERO;
            digitIndex_r   <= 2'd0;
            valueShadow_r  <= 16'h0000;
            enableShadow_r <= 4'h0;
            dpShadow_r     <= 4'h0;
        end else begin
            prescaler_r <= prescaler_r + PRESCALER_ONE;
            if (tick_s) begin
                digitIndex_r <= digitIndex_r + 2'd1;
            end else begin
                digitIndex_r <= digitIndex_r;
            end
            if (frameEnd_s) begin
                valueShadow_r  <= value;
                enableShadow_r <= digitEnable;
                dpShadow_r     <= decimalPoints;
            end else begin
                valueShadow_r  <= valueShadow_r;
                enableShadow_r <= enableShadow_r;
                dpShadow_r     <= dpShadow_r;
            end
        end
    end

    // Output registers, one clock behind the scan state they reflect.
    always_ff @(posedge systemClock) begin
        if (!resetButtonN) begin
            anodes_r       <= 4'b1111;
            segments_r     <= 7'b1111111;
            decimalPoint_r <= 1'b1;
            frameStart_r   <= 1'b0;
        end else begin
            anodes_r       <= anodesNext_s;
            segments_r     <= segmentsNext_s;
            decimalPoint_r <= decimalPointNext_s;
            frameStart_r   <= frameEnd_s;
        end
    end

    assign anodes       = anodes_r;
    assign segments     = segments_r;
    assign decimalPoint = decimalPoint_r;
    assign frameStart   = frameStart_r;

endmodule
